// File: rtl/ad_avg_if.sv
// Sample-in / result-out bundle for the ad_avg boxcar averager.
// The master drives samples and consumes results; the slave is the averager.
interface ad_avg_if #(
  parameter int DW = 16
);
  logic [DW-1:0] ad_data;
  logic          ad_vld;
  logic          avg_en;
  logic [DW-1:0] avg_data;
  logic [DW-1:0] avg_min;
  logic [DW-1:0] avg_max;
  logic          avg_vld;
  logic          avg_rdy;
  logic          ovr;
  logic          ovr_clr;

  modport master (
    output ad_data, ad_vld, avg_en, avg_rdy, ovr_clr,
    input  avg_data, avg_min, avg_max, avg_vld, ovr
  );

  modport slave (
    input  ad_data, ad_vld, avg_en, avg_rdy, ovr_clr,
    output avg_data, avg_min, avg_max, avg_vld, ovr
  );
endinterface

// File: rtl/ad_avg.sv
// Decimating boxcar averager: mean/min/max over 2^LOG2_N samples,
// one-deep valid/ready result register with sticky overrun flag.
module ad_avg #(
  parameter int DW     = 16,
  parameter int LOG2_N = 4
) (
  input logic     clk_sys,
  input logic     rst,
  ad_avg_if.slave bus
);
  localparam int AW = DW + LOG2_N;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  logic [AW-1:0]     acc;
  logic [LOG2_N-1:0] cnt;
  logic [DW-1:0]     run_min;
  logic [DW-1:0]     run_max;

  out_state_t        out_state;
  logic [DW-1:0]     res_data;
  logic [DW-1:0]     res_min;
  logic [DW-1:0]     res_max;
  logic              ovr_q;

  logic              accept;
  logic              last;
  logic [AW-1:0]     sum;
  logic [DW-1:0]     new_min;
  logic [DW-1:0]     new_max;
  logic              out_full;

  assign accept   = bus.avg_en & bus.ad_vld;
  assign last     = accept & (cnt == '1);
  assign sum      = acc + AW'(bus.ad_data);
  assign new_min  = (bus.ad_data < run_min) ? bus.ad_data : run_min;
  assign new_max  = (bus.ad_data > run_max) ? bus.ad_data : run_max;
  assign out_full = (out_state == OUT_FULL);

  // Window state clears on completion so the next sample opens a new window with no gap.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      run_min <= '1;
      run_max <= '0;
    end else if (!bus.avg_en || last) begin
      acc     <= '0;
      cnt     <= '0;
      run_min <= '1;
      run_max <= '0;
    end else if (bus.ad_vld) begin
      acc     <= sum;
      cnt     <= cnt + LOG2_N'(1);
      run_min <= new_min;
      run_max <= new_max;
    end
  end

  // A completion landing on a full, unaccepted register is dropped and flagged.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      out_state <= OUT_EMPTY;
      res_data  <= '0;
      res_min   <= '0;
      res_max   <= '0;
      ovr_q     <= 1'b0;
    end else begin
      if (last && (!out_full || bus.avg_rdy)) begin
        out_state <= OUT_FULL;
        res_data  <= sum[AW-1:LOG2_N];
        res_min   <= new_min;
        res_max   <= new_max;
      end else if (out_full && bus.avg_rdy) begin
        out_state <= OUT_EMPTY;
      end

      if (last && out_full && !bus.avg_rdy) begin
        ovr_q <= 1'b1;
      end else if (bus.ovr_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign bus.avg_vld  = out_full;
  assign bus.avg_data = res_data;
  assign bus.avg_min  = res_min;
  assign bus.avg_max  = res_max;
  assign bus.ovr      = ovr_q;
endmodule

// File: tb/tb_ad_avg.sv
// Directed bench for ad_avg: a LOG2_N=2 instance for most scenarios and a
// LOG2_N=4 instance for the full-scale accumulator case.
module tb_ad_avg;
  logic clk_sys;
  logic rst;
  int   checks;
  int   errors;

  ad_avg_if #(.DW(16)) if2 ();
  ad_avg_if #(.DW(16)) if4 ();

  ad_avg #(.DW(16), .LOG2_N(2)) dut2 (.clk_sys(clk_sys), .rst(rst), .bus(if2));
  ad_avg #(.DW(16), .LOG2_N(4)) dut4 (.clk_sys(clk_sys), .rst(rst), .bus(if4));

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Each push presents one sample across a single rising edge, starting and ending on a falling edge.
  task automatic push2(input logic [15:0] v);
    if2.ad_data = v;
    if2.ad_vld  = 1'b1;
    @(negedge clk_sys);
    if2.ad_vld  = 1'b0;
  endtask

  task automatic push4(input logic [15:0] v);
    if4.ad_data = v;
    if4.ad_vld  = 1'b1;
    @(negedge clk_sys);
    if4.ad_vld  = 1'b0;
  endtask

  task automatic test_reset();
    logic [49:0] got;
    rst = 1'b1;
    if2.ad_data = '0; if2.ad_vld = 1'b0; if2.avg_en = 1'b0; if2.avg_rdy = 1'b1; if2.ovr_clr = 1'b0;
    if4.ad_data = '0; if4.ad_vld = 1'b0; if4.avg_en = 1'b0; if4.avg_rdy = 1'b1; if4.ovr_clr = 1'b0;
    repeat (2) @(negedge clk_sys);
    got = {if2.avg_vld, if2.avg_data, if2.avg_min, if2.avg_max, if2.ovr};
    if (got !== 50'd0) begin
      errors++;
      $display("[TB] FAIL reset_n2: got %h expected %h", got, 50'd0);
    end
    checks++;
    got = {if4.avg_vld, if4.avg_data, if4.avg_min, if4.avg_max, if4.ovr};
    if (got !== 50'd0) begin
      errors++;
      $display("[TB] FAIL reset_n4: got %h expected %h", got, 50'd0);
    end
    checks++;
    rst = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_basic_mean();
    logic [48:0] got;
    if2.avg_en = 1'b1; if2.avg_rdy = 1'b1;
    push2(16'd100); push2(16'd200); push2(16'd300);
    if (if2.avg_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_early_vld: got %b expected 0", if2.avg_vld);
    end
    checks++;
    push2(16'd401);
    got = {if2.avg_vld, if2.avg_data, if2.avg_min, if2.avg_max};
    if (got !== {1'b1, 16'd250, 16'd100, 16'd401}) begin
      errors++;
      $display("[TB] FAIL basic_result: got %h expected %h", got, {1'b1, 16'd250, 16'd100, 16'd401});
    end
    checks++;
    @(negedge clk_sys);
    got = {if2.avg_vld, if2.avg_data, if2.avg_min, if2.avg_max};
    if (got !== {1'b0, 16'd250, 16'd100, 16'd401}) begin
      errors++;
      $display("[TB] FAIL basic_accepted: got %h expected %h", got, {1'b0, 16'd250, 16'd100, 16'd401});
    end
    checks++;
    if2.avg_en = 1'b0;
  endtask

  task automatic test_full_scale();
    logic [48:0] got;
    if4.avg_en = 1'b1; if4.avg_rdy = 1'b1;
    for (int i = 0; i < 16; i++) push4(16'hFFFF);
    got = {if4.avg_vld, if4.avg_data, if4.avg_min, if4.avg_max};
    if (got !== {1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF}) begin
      errors++;
      $display("[TB] FAIL full_ones: got %h expected %h", got, {1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF});
    end
    checks++;
    for (int i = 0; i < 16; i++) push4(16'h0000);
    got = {if4.avg_vld, if4.avg_data, if4.avg_min, if4.avg_max};
    if (got !== {1'b1, 16'h0000, 16'h0000, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL full_zeros: got %h expected %h", got, {1'b1, 16'h0000, 16'h0000, 16'h0000});
    end
    checks++;
    @(negedge clk_sys);
    if4.avg_en = 1'b0;
  endtask

  task automatic test_overrun();
    logic [17:0] got;
    if2.avg_en = 1'b1; if2.avg_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push2(16'd10);
    got = {if2.avg_vld, if2.avg_data, if2.ovr};
    if (got !== {1'b1, 16'd10, 1'b0}) begin
      errors++;
      $display("[TB] FAIL ovr_first: got %h expected %h", got, {1'b1, 16'd10, 1'b0});
    end
    checks++;
    for (int i = 0; i < 4; i++) push2(16'd10);
    for (int i = 0; i < 8; i++) push2(16'd20);
    got = {if2.avg_vld, if2.avg_data, if2.ovr};
    if (got !== {1'b1, 16'd10, 1'b1}) begin
      errors++;
      $display("[TB] FAIL ovr_dropped: got %h expected %h", got, {1'b1, 16'd10, 1'b1});
    end
    checks++;
    if2.avg_rdy = 1'b1;
    @(negedge clk_sys);
    if2.avg_rdy = 1'b0;
    got = {if2.avg_vld, if2.avg_data, if2.ovr};
    if (got !== {1'b0, 16'd10, 1'b1}) begin
      errors++;
      $display("[TB] FAIL ovr_accept: got %h expected %h", got, {1'b0, 16'd10, 1'b1});
    end
    checks++;
    if2.ovr_clr = 1'b1;
    @(negedge clk_sys);
    if2.ovr_clr = 1'b0;
    if (if2.ovr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovr_clear: got %b expected 0", if2.ovr);
    end
    checks++;
  endtask

  task automatic test_enable();
    logic [48:0] got;
    if2.avg_en = 1'b1; if2.avg_rdy = 1'b1;
    push2(16'd50); push2(16'd50);
    if2.avg_en = 1'b0;
    @(negedge clk_sys);
    if2.avg_en = 1'b1;
    push2(16'd8); push2(16'd8);
    if (if2.avg_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL en_partial_kept: got %b expected 0", if2.avg_vld);
    end
    checks++;
    push2(16'd8); push2(16'd8);
    got = {if2.avg_vld, if2.avg_data, if2.avg_min, if2.avg_max};
    if (got !== {1'b1, 16'd8, 16'd8, 16'd8}) begin
      errors++;
      $display("[TB] FAIL en_fresh_window: got %h expected %h", got, {1'b1, 16'd8, 16'd8, 16'd8});
    end
    checks++;
    @(negedge clk_sys);
    push2(16'd1); push2(16'd1); push2(16'd1);
    if2.avg_en = 1'b0;
    push2(16'd1);
    if (if2.avg_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL en_final_ignored: got %b expected 0", if2.avg_vld);
    end
    checks++;
    if2.avg_en = 1'b1;
    for (int i = 0; i < 4; i++) push2(16'd7);
    got = {if2.avg_vld, if2.avg_data, if2.avg_min, if2.avg_max};
    if (got !== {1'b1, 16'd7, 16'd7, 16'd7}) begin
      errors++;
      $display("[TB] FAIL en_after_abort: got %h expected %h", got, {1'b1, 16'd7, 16'd7, 16'd7});
    end
    checks++;
    @(negedge clk_sys);
  endtask

  task automatic test_back_to_back();
    logic [49:0] got;
    if2.avg_rdy = 1'b1;
    for (int i = 0; i < 4; i++) push2(16'd20);
    if2.avg_rdy = 1'b0;
    push2(16'd40); push2(16'd40); push2(16'd40);
    if2.avg_rdy = 1'b1;
    push2(16'd44);
    got = {if2.avg_vld, if2.avg_data, if2.avg_min, if2.avg_max, if2.ovr};
    if (got !== {1'b1, 16'd41, 16'd40, 16'd44, 1'b0}) begin
      errors++;
      $display("[TB] FAIL b2b_reload: got %h expected %h", got, {1'b1, 16'd41, 16'd40, 16'd44, 1'b0});
    end
    checks++;
    if2.avg_rdy = 1'b0;
    push2(16'd1); push2(16'd2); push2(16'd3);
    if2.ovr_clr = 1'b1;
    push2(16'd4);
    if2.ovr_clr = 1'b0;
    got = {if2.avg_vld, if2.avg_data, if2.avg_min, if2.avg_max, if2.ovr};
    if (got !== {1'b1, 16'd41, 16'd40, 16'd44, 1'b1}) begin
      errors++;
      $display("[TB] FAIL b2b_set_beats_clr: got %h expected %h", got, {1'b1, 16'd41, 16'd40, 16'd44, 1'b1});
    end
    checks++;
    if2.avg_rdy = 1'b1; if2.ovr_clr = 1'b1;
    @(negedge clk_sys);
    if2.ovr_clr = 1'b0;
    got = {if2.avg_vld, if2.avg_data, if2.avg_min, if2.avg_max, if2.ovr};
    if (got !== {1'b0, 16'd41, 16'd40, 16'd44, 1'b0}) begin
      errors++;
      $display("[TB] FAIL b2b_drain: got %h expected %h", got, {1'b0, 16'd41, 16'd40, 16'd44, 1'b0});
    end
    checks++;
  endtask

  task automatic test_mid_reset();
    logic [49:0] got;
    logic [48:0] res;
    if2.avg_rdy = 1'b1;
    push2(16'd9); push2(16'd9); push2(16'd9);
    #2 rst = 1'b1;
    #1;
    got = {if2.avg_vld, if2.avg_data, if2.avg_min, if2.avg_max, if2.ovr};
    if (got !== 50'd0) begin
      errors++;
      $display("[TB] FAIL rst_async: got %h expected %h", got, 50'd0);
    end
    checks++;
    @(negedge clk_sys);
    rst = 1'b0;
    push2(16'd4); push2(16'd4); push2(16'd4); push2(16'd8);
    res = {if2.avg_vld, if2.avg_data, if2.avg_min, if2.avg_max};
    if (res !== {1'b1, 16'd5, 16'd4, 16'd8}) begin
      errors++;
      $display("[TB] FAIL rst_new_window: got %h expected %h", res, {1'b1, 16'd5, 16'd4, 16'd8});
    end
    checks++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_mean();
    test_full_scale();
    test_overrun();
    test_enable();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ad_avg.md
Name: ad_avg

Overview:
Decimating boxcar averager directly downstream of the ADC serial-to-parallel stage. Consumes the 16-bit ad_data/ad_vld sample stream and accumulates 2^LOG2_N consecutive samples. Once per window it emits the truncated mean plus the window min/max on a valid/ready output port. Adds a sticky overrun flag for windows lost to back-pressure.

Parameters:
DW, 16, sample and result width (unsigned)
LOG2_N, 4, log2 of window length; N = 2^LOG2_N samples per result (legal 1..8)

Ports:
clk_sys  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
ad_data  in  DW  sample from ADC s2p stage; sampled only when ad_vld=1
ad_vld  in  1  one-cycle sample strobe
avg_en  in  1  1 = accumulate; 0 = discard partial window and idle
avg_data  out  DW  window mean, floor(sum / N)
avg_min  out  DW  smallest sample in window
avg_max  out  DW  largest sample in window
avg_vld  out  1  result valid; held until accepted
avg_rdy  in  1  consumer ready; transfer when avg_vld & avg_rdy
ovr  out  1  sticky: a completed window was dropped
ovr_clr  in  1  clears ovr

Behaviour:
- Reset: acc=0, cnt=0, run_min=all-ones, run_max=0. avg_data/avg_min/avg_max=0, avg_vld=0, ovr=0. Takes effect immediately (asynchronous). Any partial window is lost.
- Accumulator is DW+LOG2_N bits wide and never overflows. cnt is LOG2_N bits wide.
- Accumulate when avg_en=1 & ad_vld=1:
  - acc += ad_data
  - run_min = min(run_min, ad_data); run_max = max(run_max, ad_data)
  - cnt += 1
- Window complete when cnt==N-1 and a sample is accepted:
  - completion value = (acc+ad_data) >> LOG2_N, truncated; min/max include the final sample.
  - acc, cnt, run_min and run_max return to their reset values in the same cycle, so the next sample opens a new window with no gap.
- Latency: avg_vld asserts on the clock edge that accepts the final sample, i.e. it is visible in the cycle after that ad_vld.
- Output register load rules:
  - avg_vld=0 at completion: load result, avg_vld<=1.
  - avg_vld=1 & avg_rdy=1 at completion: load new result, avg_vld stays 1, ovr unchanged.
  - avg_vld=1 & avg_rdy=0 at completion: new result dropped, output holds the old values, ovr<=1.
  - avg_vld=1 & avg_rdy=1, no completion: avg_vld<=0; data outputs hold their last values.
- Output stability: avg_data/avg_min/avg_max change only when a result is loaded.
- ovr: set has priority over ovr_clr in the same cycle; otherwise ovr_clr=1 -> ovr<=0.
- avg_en=0:
  - acc, cnt, run_min and run_max are forced to reset values; ad_vld is ignored.
  - The output register and handshake keep operating, so a pending result can still be accepted.
  - When avg_en returns to 1, a fresh window starts.
- avg_en falling in the same cycle as a would-be final sample: the sample is ignored and no result is produced.
- State summary: cnt==0 = WAIT_FIRST; cnt in 1..N-1 = ACCUM; output side is EMPTY or FULL (avg_vld).

Test Plan:
- LOG2_N=2, avg_en=1, avg_rdy=1, samples 100,200,300,401 -> one cycle after 4th ad_vld: avg_vld=1 for one cycle, avg_data=250, avg_min=100, avg_max=401.
- LOG2_N=4, 16 samples of 0xFFFF then 16 of 0x0000 -> results 0xFFFF then 0x0000 with no accumulator wrap; min/max 0xFFFF/0xFFFF then 0/0.
- LOG2_N=2, avg_rdy=0, 8 samples of value 10 then 8 of value 20:
  - first result (10) held; windows 2-4 dropped; ovr=1.
  - pulse avg_rdy -> avg_vld falls, avg_data still 10.
  - ovr_clr -> ovr=0.
- LOG2_N=2, avg_en drops after 2 samples (50,50), re-enabled, then samples 8,8,8,8 -> exactly one result, avg_data=8.
- Completion coinciding with avg_rdy=1 while avg_vld=1 -> new value loaded, avg_vld stays 1, ovr stays 0. Completion-drop coinciding with ovr_clr=1 -> ovr=1.
- Assert rst for one cycle mid-window (after 3 of 4 samples) -> all outputs 0 immediately; the next 4 samples (4,4,4,8) give avg_data=5.
